// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result handshake bundle between execute stage and muldiv_unit.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface muldiv_unit_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_funct3;
   logic [XLEN-1:0]  in_a;
   logic [XLEN-1:0]  in_b;
   logic [TAG_W-1:0] in_rd;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_data;
   logic [TAG_W-1:0] out_rd;
   logic             busy;

   // Pipeline side: issues operations, consumes results.
   modport master (
      output in_valid, in_funct3, in_a, in_b, in_rd, flush, out_ready,
      input  in_ready, out_valid, out_data, out_rd, busy
   );

   // Unit side.
   modport slave (
      input  in_valid, in_funct3, in_a, in_b, in_rd, flush, out_ready,
      output in_ready, out_valid, out_data, out_rd, busy
   );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit beside the execute-stage ALU.
// Latency: XLEN+2 cycles accept-to-result (XLEN iterations, fix-up, DONE); 1 cycle for divide-by-zero/overflow.
// Backpressure: one op in flight, in_ready low while busy; result held in DONE until out_ready; flush kills all.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5,
   parameter int CNT_W = 6
) (
   input logic          clock,
   input logic          reset,
   muldiv_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state;
   logic [2:0]       op;
   logic [TAG_W-1:0] rd_tag;
   logic [TAG_W-1:0] rd_out;
   logic [XLEN-1:0]  acc_hi;
   logic [XLEN-1:0]  acc_lo;
   logic [XLEN-1:0]  b_mag;
   logic [XLEN-1:0]  data_out;
   logic             neg_quo;
   logic             neg_rem;
   logic             valid_out;
   logic             busy_out;
   logic [CNT_W-1:0] cnt;

   // Request decode: operand signedness, magnitudes and the cases resolved without iterating.
   logic            is_div;
   logic            a_signed;
   logic            b_signed;
   logic            sign_a;
   logic            sign_b;
   logic            div_zero;
   logic            div_ovf;
   logic [XLEN-1:0] a_abs;
   logic [XLEN-1:0] b_abs;
   logic [XLEN-1:0] min_neg;
   logic [XLEN-1:0] special_res;

   assign is_div   = bus.in_funct3[2];
   assign a_signed = (bus.in_funct3 == 3'd1) || (bus.in_funct3 == 3'd2) ||
                     (bus.in_funct3 == 3'd4) || (bus.in_funct3 == 3'd6);
   assign b_signed = (bus.in_funct3 == 3'd1) || (bus.in_funct3 == 3'd4) ||
                     (bus.in_funct3 == 3'd6);
   assign sign_a   = a_signed && bus.in_a[XLEN-1];
   assign sign_b   = b_signed && bus.in_b[XLEN-1];
   assign a_abs    = sign_a ? -bus.in_a : bus.in_a;
   assign b_abs    = sign_b ? -bus.in_b : bus.in_b;
   assign min_neg  = {1'b1, {(XLEN-1){1'b0}}};
   assign div_zero = is_div && (bus.in_b == '0);
   // funct3[0] clear means signed divide/remainder.
   assign div_ovf  = is_div && !bus.in_funct3[0] && (bus.in_a == min_neg) && (bus.in_b == '1);
   // funct3[1] set selects the remainder.
   assign special_res = div_zero ? (bus.in_funct3[1] ? bus.in_a : '1)
                                 : (bus.in_funct3[1] ? '0 : bus.in_a);

   // One iteration: shift-add for multiply (product in acc_hi:acc_lo, multiplier
   // shifting out of acc_lo), restoring shift-subtract for divide (remainder in
   // acc_hi, dividend shifting out of and quotient shifting into acc_lo).
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_sh;
   logic [XLEN-1:0] div_diff;
   logic            div_ok;

   assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : '0);
   assign div_sh   = {acc_hi, acc_lo[XLEN-1]};
   assign div_ok   = div_sh >= {1'b0, b_mag};
   assign div_diff = div_sh[XLEN-1:0] - b_mag;

   // Fix-up: magnitudes back to two's complement.
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix;
   logic [XLEN-1:0]   rem_fix;
   logic [XLEN-1:0]   fix_res;

   assign prod_fix = neg_quo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
   assign quo_fix  = neg_quo ? -acc_lo : acc_lo;
   assign rem_fix  = neg_rem ? -acc_hi : acc_hi;

   // Pick the half/part of the iteration result that the opcode returns.
   always_comb begin
      fix_res = rem_fix;
      case (op)
         3'd0:             fix_res = prod_fix[XLEN-1:0];
         3'd1, 3'd2, 3'd3: fix_res = prod_fix[2*XLEN-1:XLEN];
         3'd4, 3'd5:       fix_res = quo_fix;
         default:          fix_res = rem_fix;
      endcase
   end

   assign bus.in_ready  = (state == IDLE) && !bus.flush;
   assign bus.out_valid = valid_out;
   assign bus.out_data  = data_out;
   assign bus.out_rd    = rd_out;
   assign bus.busy      = busy_out;

   // Control FSM with the iterative datapath; flush wins over accept and completion.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         op        <= '0;
         rd_tag    <= '0;
         rd_out    <= '0;
         acc_hi    <= '0;
         acc_lo    <= '0;
         b_mag     <= '0;
         data_out  <= '0;
         neg_quo   <= 1'b0;
         neg_rem   <= 1'b0;
         valid_out <= 1'b0;
         busy_out  <= 1'b0;
         cnt       <= '0;
      end else if (bus.flush) begin
         state     <= IDLE;
         valid_out <= 1'b0;
         busy_out  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  op       <= bus.in_funct3;
                  rd_tag   <= bus.in_rd;
                  cnt      <= '0;
                  acc_hi   <= '0;
                  acc_lo   <= a_abs;
                  b_mag    <= b_abs;
                  neg_quo  <= sign_a ^ sign_b;
                  neg_rem  <= sign_a;
                  busy_out <= 1'b1;
                  if (div_zero || div_ovf) begin
                     data_out  <= special_res;
                     rd_out    <= bus.in_rd;
                     valid_out <= 1'b1;
                     state     <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (op[2]) begin
                  acc_hi <= div_ok ? div_diff : div_sh[XLEN-1:0];
                  acc_lo <= {acc_lo[XLEN-2:0], div_ok};
               end else begin
                  acc_hi <= mul_sum[XLEN:1];
                  acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
               end
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(XLEN-1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               data_out  <= fix_res;
               rd_out    <= rd_tag;
               valid_out <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  valid_out <= 1'b0;
                  busy_out  <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed RV32M cases plus random traffic against a behavioural model.
// Latency: model predicts 1 cycle for special divides, XLEN+2 otherwise.
// Backpressure: out_ready and flush are randomised; the model tracks acceptance and delivery.
module tb_muldiv_unit;
   localparam int XLEN = 32;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   muldiv_unit_if #(.XLEN(XLEN), .TAG_W(5)) bus ();

   muldiv_unit #(.XLEN(XLEN), .TAG_W(5), .CNT_W(6)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // RV32M result from plain integer arithmetic.
   function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      int          ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      ia = $signed(a);
      ib = $signed(b);
      p  = '0;
      ref_result = '0;
      case (f)
         3'd0: begin p = ua * ub; ref_result = p[31:0];  end
         3'd1: begin p = sa * sb; ref_result = p[63:32]; end
         3'd2: begin p = sa * ub; ref_result = p[63:32]; end
         3'd3: begin p = ua * ub; ref_result = p[63:32]; end
         3'd4: begin
            if (b == 32'd0) ref_result = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = a;
            else ref_result = 32'(ia / ib);
         end
         3'd5: ref_result = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) ref_result = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = 32'd0;
            else ref_result = 32'(ia % ib);
         end
         default: ref_result = (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   function automatic bit ref_special(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
      ref_special = f[2] && ((b == 32'd0) ||
                    (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   // Model: one op in flight; m_t counts edges since accept (accept edge = 1).
   bit          m_pend = 1'b0;
   int          m_t    = 0;
   int          m_lat  = 0;
   logic [31:0] m_data = '0;
   logic [4:0]  m_rd   = '0;

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_pend = 1'b0;
      end else if (bus.flush) begin
         m_pend = 1'b0;
      end else if (!m_pend) begin
         if (bus.in_valid) begin
            m_pend = 1'b1;
            m_t    = 1;
            m_data = ref_result(bus.in_funct3, bus.in_a, bus.in_b);
            m_rd   = bus.in_rd;
            m_lat  = ref_special(bus.in_funct3, bus.in_a, bus.in_b) ? 1 : XLEN + 2;
         end
      end else if (m_t >= m_lat && bus.out_ready) begin
         m_pend = 1'b0;
      end else begin
         m_t++;
      end
   end

   // Compare DUT outputs with the model every cycle while out of reset.
   always @(negedge clock) begin
      if (reset) begin
         chk("out_valid", 64'(bus.out_valid), 64'(m_pend && m_t >= m_lat));
         chk("busy", 64'(bus.busy), 64'(m_pend));
         chk("in_ready", 64'(bus.in_ready), 64'(!m_pend && !bus.flush));
         if (m_pend && m_t >= m_lat) begin
            chk("out_data", 64'(bus.out_data), 64'(m_data));
            chk("out_rd", 64'(bus.out_rd), 64'(m_rd));
         end
      end
   end

   // Issue one op and wait for its result; checks latency and literal value.
   task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
      int n;
      @(posedge clock); #1;
      bus.in_valid  = 1'b1;
      bus.in_funct3 = f;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_rd     = rd;
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      bus.in_a     = $urandom;
      bus.in_b     = $urandom;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!bus.out_valid && n < 100);
      chk({name, " latency"}, 64'(n), 64'(exp_lat));
      chk({name, " data"}, 64'(bus.out_data), 64'(exp));
      chk({name, " rd"}, 64'(bus.out_rd), 64'(rd));
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] s;
      s = 32'($urandom_range(0, 20));
      case ($urandom_range(0, 7))
         0:       pick = 32'd0;
         1:       pick = 32'hFFFF_FFFF;
         2:       pick = 32'h8000_0000;
         3:       pick = s;
         4:       pick = -s;
         default: pick = $urandom;
      endcase
   endfunction

   initial begin
      int seen;
      bus.in_valid  = 1'b0;
      bus.in_funct3 = 3'd0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_rd     = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;

      // Reset state.
      repeat (2) @(negedge clock);
      chk("rst out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst busy", 64'(bus.busy), 64'd0);
      chk("rst out_data", 64'(bus.out_data), 64'd0);
      chk("rst out_rd", 64'(bus.out_rd), 64'd0);
      reset = 1'b1;
      @(negedge clock);
      chk("post-rst in_ready", 64'(bus.in_ready), 64'd1);

      // Directed arithmetic.
      do_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 34);
      do_op("MULH", 3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, 34);
      do_op("MULHU", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 32'h7FFF_FFFF, 34);
      do_op("MULHSU", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h8000_0000, 34);
      do_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 34);
      do_op("REM -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 34);
      do_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 34);
      do_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 34);
      do_op("DIV 5/0", 3'd4, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1);
      do_op("REM 5/0", 3'd6, 32'd5, 32'd0, 5'd10, 32'd5, 1);
      do_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
      do_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1);

      // Backpressure: result held in DONE.
      @(posedge clock); #1;
      bus.out_ready = 1'b0;
      do_op("MUL bp", 3'd0, 32'd12345, 32'd678, 5'd13, 32'd8369910, 34);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         chk("bp out_valid held", 64'(bus.out_valid), 64'd1);
         chk("bp out_data held", 64'(bus.out_data), 64'd8369910);
      end
      @(posedge clock); #1;
      bus.out_ready = 1'b1;
      @(negedge clock);
      @(negedge clock);
      chk("bp release in_ready", 64'(bus.in_ready), 64'd1);
      chk("bp release out_valid", 64'(bus.out_valid), 64'd0);

      // Flush mid-CALC: no result ever.
      @(posedge clock); #1;
      bus.in_valid  = 1'b1;
      bus.in_funct3 = 3'd1;
      bus.in_a      = 32'h1234_5678;
      bus.in_b      = 32'h8765_4321;
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clock);
      #1 bus.flush = 1'b1;
      @(posedge clock); #1;
      bus.flush = 1'b0;
      seen = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clock);
         if (bus.out_valid) seen++;
      end
      chk("flush no result", 64'(seen), 64'd0);
      chk("flush busy", 64'(bus.busy), 64'd0);

      // Flush together with in_valid: no accept.
      @(posedge clock); #1;
      bus.in_valid = 1'b1;
      bus.flush    = 1'b1;
      @(negedge clock);
      chk("flush+valid in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      @(negedge clock);
      chk("flush+valid busy", 64'(bus.busy), 64'd0);

      // Reset mid-CALC clears outputs asynchronously.
      @(posedge clock); #1;
      bus.in_valid  = 1'b1;
      bus.in_funct3 = 3'd5;
      bus.in_a      = 32'd999;
      bus.in_b      = 32'd10;
      bus.in_rd     = 5'd21;
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      repeat (5) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      chk("mid-rst out_valid", 64'(bus.out_valid), 64'd0);
      chk("mid-rst busy", 64'(bus.busy), 64'd0);
      chk("mid-rst out_data", 64'(bus.out_data), 64'd0);
      chk("mid-rst out_rd", 64'(bus.out_rd), 64'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("post mid-rst in_ready", 64'(bus.in_ready), 64'd1);

      // Random traffic: requests every cycle (ignored while busy), random
      // out_ready stalls and occasional flushes.
      for (int c = 0; c < 4000; c++) begin
         @(posedge clock); #1;
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.in_funct3 = 3'($urandom_range(0, 7));
         bus.in_a      = pick();
         bus.in_b      = pick();
         bus.in_rd     = 5'($urandom_range(0, 31));
         bus.flush     = ($urandom_range(0, 99) == 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clock); #1;
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      repeat (40) @(posedge clock);
      @(negedge clock);
      chk("drain idle", 64'(bus.busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
